// File: rtl/dmem_pkg.sv
// Shared types and defaults for the AVR data-space SRAM (dmem_sram).
// Defining DMEM_CLEAR_EN enables the post-reset zero sweep.
package dmem_pkg;

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        IDLE  = 2'd1,
        WORD2 = 2'd2
    } state_t;

    localparam int DMEM_DATA_W = 8;
    localparam int DMEM_ADDR_W = 12;
    localparam int DMEM_BASE   = 256;
    localparam int DMEM_DEPTH  = 2048;

    // a is taken at full width so that addr+1 past the top never wraps into the window
    function automatic logic in_window(input int a,
                                       input int base  = DMEM_BASE,
                                       input int depth = DMEM_DEPTH);
        return (a >= base) && (a < base + depth);
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Synchronous single-port byte store for dmem_sram: one read or write per cycle,
// read data registered on the same edge that samples the offset.
module dmem_array #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 2048,
    parameter int OFF_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic [OFF_W-1:0]  off,
    input  logic              we,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[off] <= din;
        end
        dout <= mem[off];
    end

endmodule

// File: rtl/dmem_sram.sv
// Data-space SRAM: window decode, two-cycle word sequencing and output registers
// around dmem_array. Optional clear sweep after reset under DMEM_CLEAR_EN.
module dmem_sram
    import dmem_pkg::*;
#(
    parameter int DATA_W = DMEM_DATA_W,
    parameter int ADDR_W = DMEM_ADDR_W,
    parameter int BASE   = DMEM_BASE,
    parameter int DEPTH  = DMEM_DEPTH
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req,
    input  logic                we,
    input  logic                wide,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [2*DATA_W-1:0] di,
    output logic                ready,
    output logic [2*DATA_W-1:0] dout,
    output logic                dvalid,
    output logic                oob
);

    localparam int OFF_W = $clog2(DEPTH);

`ifdef DMEM_CLEAR_EN
    localparam state_t RESET_STATE = CLEAR;
    logic [OFF_W-1:0] clr_ptr;
`else
    localparam state_t RESET_STATE = IDLE;
`endif

    state_t state, next_state;

    logic [ADDR_W:0]   word_addr;
    logic              word_we;
    logic [DATA_W-1:0] word_hi;

    logic              acc_en;
    logic              acc_we;
    logic              acc_read;
    logic              acc_lo;
    logic              acc_hi;
    logic              acc_inwin;
    logic [ADDR_W:0]   acc_addr;
    logic              clear_we;

    logic [OFF_W-1:0]  arr_off;
    logic              arr_we;
    logic [DATA_W-1:0] arr_din;
    logic [DATA_W-1:0] arr_q;

    logic              p_read;
    logic              p_zero;
    logic              p_lo;
    logic              p_hi;
    logic [DATA_W-1:0] lo_hold;
    logic [DATA_W-1:0] rd_byte;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RESET_STATE;
`ifdef DMEM_CLEAR_EN
            clr_ptr <= '0;
`endif
        end else begin
            state <= next_state;
`ifdef DMEM_CLEAR_EN
            if (state == CLEAR) begin
                clr_ptr <= clr_ptr + OFF_W'(1);
            end
`endif
        end
    end

    // Choose which byte the single port touches this cycle and where the FSM goes next
    always_comb begin
        next_state = state;
        ready      = 1'b0;
        acc_en     = 1'b0;
        acc_we     = 1'b0;
        acc_read   = 1'b0;
        acc_lo     = 1'b0;
        acc_hi     = 1'b0;
        acc_addr   = '0;
        clear_we   = 1'b0;
        arr_din    = di[DATA_W-1:0];
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (req) begin
                    acc_en   = 1'b1;
                    acc_addr = {1'b0, addr};
                    acc_we   = we;
                    acc_read = !we;
                    acc_lo   = wide;
                    if (wide) begin
                        next_state = WORD2;
                    end
                end
            end
            WORD2: begin
                acc_en     = 1'b1;
                acc_addr   = word_addr;
                acc_we     = word_we;
                acc_read   = !word_we;
                acc_hi     = 1'b1;
                arr_din    = word_hi;
                next_state = IDLE;
            end
`ifdef DMEM_CLEAR_EN
            CLEAR: begin
                clear_we = 1'b1;
                arr_din  = '0;
                if (clr_ptr == OFF_W'(DEPTH - 1)) begin
                    next_state = IDLE;
                end
            end
`endif
            default: next_state = IDLE;
        endcase

        acc_inwin = in_window(int'(acc_addr), BASE, DEPTH);
        arr_we    = (acc_en && acc_we && acc_inwin) || clear_we;
`ifdef DMEM_CLEAR_EN
        arr_off   = clear_we ? clr_ptr : OFF_W'(acc_addr - (ADDR_W+1)'(BASE));
`else
        arr_off   = OFF_W'(acc_addr - (ADDR_W+1)'(BASE));
`endif
    end

    dmem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .OFF_W  (OFF_W)
    ) u_array (
        .clk  (clk),
        .off  (arr_off),
        .we   (arr_we),
        .din  (arr_din),
        .dout (arr_q)
    );

    assign rd_byte = p_zero ? '0 : arr_q;

    // Word latch, oob pulse, and the read-return stage that assembles dout one edge after the array read
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_addr <= '0;
            word_we   <= 1'b0;
            word_hi   <= '0;
            p_read    <= 1'b0;
            p_zero    <= 1'b0;
            p_lo      <= 1'b0;
            p_hi      <= 1'b0;
            lo_hold   <= '0;
            oob       <= 1'b0;
            dout      <= '0;
            dvalid    <= 1'b0;
        end else begin
            if (state == IDLE && req && wide) begin
                word_addr <= {1'b0, addr} + (ADDR_W+1)'(1);
                word_we   <= we;
                word_hi   <= di[2*DATA_W-1:DATA_W];
            end
            oob    <= acc_en && !acc_inwin;
            p_read <= acc_en && acc_read;
            p_zero <= !acc_inwin;
            p_lo   <= acc_lo;
            p_hi   <= acc_hi;
            dout   <= '0;
            dvalid <= 1'b0;
            if (p_read) begin
                if (p_lo) begin
                    lo_hold <= rd_byte;
                end else if (p_hi) begin
                    dout   <= {rd_byte, lo_hold};
                    dvalid <= 1'b1;
                end else begin
                    dout   <= {{DATA_W{1'b0}}, rd_byte};
                    dvalid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_sram.sv
// Self-checking bench for dmem_sram: directed scenarios plus randomized traffic
// checked against a byte-array model of the data window. Works with or without DMEM_CLEAR_EN.
module tb_dmem_sram;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic        wide = 1'b0;
    logic [11:0] addr = '0;
    logic [15:0] di = '0;
    logic        ready;
    logic [15:0] dout;
    logic        dvalid;
    logic        oob;

    int checks = 0;
    int passes = 0;

    logic [7:0] model_mem [4096];

`ifdef DMEM_CLEAR_EN
    localparam int EXP_CLEAR_CYCLES = 2048;
`else
    localparam int EXP_CLEAR_CYCLES = 0;
`endif

    dmem_sram dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req),
        .we     (we),
        .wide   (wide),
        .addr   (addr),
        .di     (di),
        .ready  (ready),
        .dout   (dout),
        .dvalid (dvalid),
        .oob    (oob)
    );

    always #5 clk = ~clk;

    function automatic bit in_ram(int a);
        return (a >= 256) && (a < 256 + 2048);
    endfunction

    function automatic logic [15:0] model_read(int a, bit wd);
        logic [7:0] lo, hi;
        lo = in_ram(a) ? model_mem[a] : 8'h00;
        hi = (wd && in_ram(a + 1)) ? model_mem[a + 1] : 8'h00;
        return {hi, lo};
    endfunction

    function automatic int model_oob(int a, bit wd);
        return (in_ram(a) ? 0 : 1) + ((wd && !in_ram(a + 1)) ? 1 : 0);
    endfunction

    task automatic model_write(int a, bit wd, logic [15:0] d);
        if (in_ram(a)) model_mem[a] = d[7:0];
        if (wd && in_ram(a + 1)) model_mem[a + 1] = d[15:8];
    endtask

    task automatic model_zero();
        for (int i = 0; i < 4096; i++) model_mem[i] = 8'h00;
    endtask

    // Issue one access once ready, then watch five negedges (index 0 = just after the accept edge)
    task automatic applyStimulus(input logic w, input logic wd, input logic [11:0] a,
                                 input logic [15:0] d, output logic [15:0] rdata,
                                 output int dv_cnt, output int dv_idx, output int oob_cnt,
                                 output int rdy_low, output int idle_nz);
        int t;
        t = 0;
        while (ready !== 1'b1 && t < 5000) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (ready !== 1'b1) $display("[TB] FAIL ready_timeout: ready=%b, required 1", ready);
        else passes++;
        req = 1'b1; we = w; wide = wd; addr = a; di = d;
        @(negedge clk);
        req = 1'b0; we = 1'b0; wide = 1'b0;
        rdata = '0; dv_cnt = 0; dv_idx = -1; oob_cnt = 0; rdy_low = 0; idle_nz = 0;
        for (int i = 0; i < 5; i++) begin
            if (dvalid === 1'b1) begin
                dv_cnt++;
                dv_idx = i;
                rdata = dout;
            end else if (dout !== 16'h0000) begin
                idle_nz++;
            end
            if (oob === 1'b1) oob_cnt++;
            if (ready !== 1'b1) rdy_low++;
            if (i < 4) @(negedge clk);
        end
    endtask

    task automatic wait_ready_after_release(output int cnt);
        cnt = 0;
        while (ready !== 1'b1 && cnt < 3000) begin
            cnt++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        int cnt;
        logic [15:0] rd;
        int dvc, dvi, oc, rl, nz;
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        checks++;
        if (ready !== (EXP_CLEAR_CYCLES == 0) || dvalid !== 1'b0 || oob !== 1'b0 || dout !== 16'h0000)
            $display("[TB] FAIL reset_outputs: ready=%b dvalid=%b oob=%b dout=%h, required ready=%0d dvalid=0 oob=0 dout=0000",
                     ready, dvalid, oob, dout, (EXP_CLEAR_CYCLES == 0));
        else passes++;
        @(negedge clk);
        rst_n = 1'b1;
        wait_ready_after_release(cnt);
        checks++;
        if (cnt !== EXP_CLEAR_CYCLES)
            $display("[TB] FAIL clear_length: ready low %0d cycles, required %0d", cnt, EXP_CLEAR_CYCLES);
        else passes++;
`ifndef DMEM_CLEAR_EN
        // Without the sweep, contents are undefined: zero the window by hand first
        for (int a = 256; a < 2304; a++) applyStimulus(1'b1, 1'b0, 12'(a), 16'h0000, rd, dvc, dvi, oc, rl, nz);
`endif
        model_zero();
        applyStimulus(1'b0, 1'b0, 12'h100, 16'h0000, rd, dvc, dvi, oc, rl, nz);
        checks++;
        if (rd !== 16'h0000 || dvc !== 1 || dvi !== 1)
            $display("[TB] FAIL first_read: dout=%h dvalid_cnt=%0d at=%0d, required 0000/1/1", rd, dvc, dvi);
        else passes++;
    endtask

    task automatic test_byte();
        logic [15:0] rd;
        int dvc, dvi, oc, rl, nz;
        applyStimulus(1'b1, 1'b0, 12'h8FF, 16'hC35A, rd, dvc, dvi, oc, rl, nz);
        model_write(12'h8FF, 1'b0, 16'hC35A);
        checks++;
        if (dvc !== 0 || oc !== 0 || rl !== 0)
            $display("[TB] FAIL byte_write: dvalid_cnt=%0d oob_cnt=%0d ready_low=%0d, required 0/0/0", dvc, oc, rl);
        else passes++;
        applyStimulus(1'b0, 1'b0, 12'h8FF, 16'h0000, rd, dvc, dvi, oc, rl, nz);
        checks++;
        if (rd !== 16'h005A || dvc !== 1 || dvi !== 1 || oc !== 0 || nz !== 0)
            $display("[TB] FAIL byte_read: dout=%h dvc=%0d at=%0d oob=%0d idle_nz=%0d, required 005A/1/1/0/0",
                     rd, dvc, dvi, oc, nz);
        else passes++;
    endtask

    task automatic test_word();
        logic [15:0] rd;
        int dvc, dvi, oc, rl, nz;
        applyStimulus(1'b1, 1'b1, 12'h200, 16'hBEEF, rd, dvc, dvi, oc, rl, nz);
        model_write(12'h200, 1'b1, 16'hBEEF);
        checks++;
        if (rl !== 1 || dvc !== 0 || oc !== 0)
            $display("[TB] FAIL word_write: ready_low=%0d dvc=%0d oob=%0d, required 1/0/0", rl, dvc, oc);
        else passes++;
        applyStimulus(1'b0, 1'b1, 12'h200, 16'h0000, rd, dvc, dvi, oc, rl, nz);
        checks++;
        if (rd !== 16'hBEEF || dvc !== 1 || dvi !== 2 || rl !== 1 || nz !== 0)
            $display("[TB] FAIL word_read: dout=%h dvc=%0d at=%0d ready_low=%0d idle_nz=%0d, required BEEF/1/2/1/0",
                     rd, dvc, dvi, rl, nz);
        else passes++;
        applyStimulus(1'b0, 1'b0, 12'h201, 16'h0000, rd, dvc, dvi, oc, rl, nz);
        checks++;
        if (rd !== 16'h00BE)
            $display("[TB] FAIL word_high_byte: dout=%h, required 00BE", rd);
        else passes++;
    endtask

    task automatic test_word_edge();
        logic [15:0] rd;
        int dvc, dvi, oc, rl, nz;
        applyStimulus(1'b1, 1'b1, 12'h8FF, 16'h1234, rd, dvc, dvi, oc, rl, nz);
        model_write(12'h8FF, 1'b1, 16'h1234);
        checks++;
        if (oc !== 1)
            $display("[TB] FAIL edge_word_write_oob: oob_cnt=%0d, required 1", oc);
        else passes++;
        applyStimulus(1'b0, 1'b0, 12'h8FF, 16'h0000, rd, dvc, dvi, oc, rl, nz);
        checks++;
        if (rd !== 16'h0034 || oc !== 0)
            $display("[TB] FAIL edge_low_byte: dout=%h oob=%0d, required 0034/0", rd, oc);
        else passes++;
        applyStimulus(1'b0, 1'b1, 12'h8FF, 16'h0000, rd, dvc, dvi, oc, rl, nz);
        checks++;
        if (rd !== 16'h0034 || oc !== 1 || dvi !== 2)
            $display("[TB] FAIL edge_word_read: dout=%h oob=%0d at=%0d, required 0034/1/2", rd, oc, dvi);
        else passes++;
    endtask

    task automatic test_oob();
        logic [15:0] rd;
        int dvc, dvi, oc, rl, nz;
        applyStimulus(1'b0, 1'b0, 12'h0FF, 16'h0000, rd, dvc, dvi, oc, rl, nz);
        checks++;
        if (rd !== 16'h0000 || oc !== 1 || dvc !== 1)
            $display("[TB] FAIL oob_read: dout=%h oob=%0d dvc=%0d, required 0000/1/1", rd, oc, dvc);
        else passes++;
        applyStimulus(1'b1, 1'b0, 12'h900, 16'h00A5, rd, dvc, dvi, oc, rl, nz);
        checks++;
        if (oc !== 1)
            $display("[TB] FAIL oob_write_flag: oob=%0d, required 1", oc);
        else passes++;
        applyStimulus(1'b1, 1'b0, 12'h0FF, 16'h0077, rd, dvc, dvi, oc, rl, nz);
        applyStimulus(1'b0, 1'b1, 12'h8FF, 16'h0000, rd, dvc, dvi, oc, rl, nz);
        checks++;
        if (rd !== model_read(12'h8FF, 1'b1))
            $display("[TB] FAIL oob_write_dropped_top: dout=%h, required %h", rd, model_read(12'h8FF, 1'b1));
        else passes++;
        applyStimulus(1'b0, 1'b0, 12'h100, 16'h0000, rd, dvc, dvi, oc, rl, nz);
        checks++;
        if (rd !== model_read(12'h100, 1'b0))
            $display("[TB] FAIL oob_write_dropped_bottom: dout=%h, required %h", rd, model_read(12'h100, 1'b0));
        else passes++;
        applyStimulus(1'b0, 1'b1, 12'hFFF, 16'h0000, rd, dvc, dvi, oc, rl, nz);
        checks++;
        if (rd !== 16'h0000 || oc !== 2)
            $display("[TB] FAIL top_word_no_wrap: dout=%h oob=%0d, required 0000/2", rd, oc);
        else passes++;
    endtask

    task automatic test_back_to_back();
        logic [15:0] rd;
        int dvc, dvi, oc, rl, nz;
        logic [11:0] a [4];
        logic [15:0] expv [4];
        for (int i = 0; i < 4; i++) begin
            a[i] = 12'(12'h400 + i * 3);
            applyStimulus(1'b1, 1'b0, a[i], 16'($urandom), rd, dvc, dvi, oc, rl, nz);
            model_write(a[i], 1'b0, di);
            expv[i] = model_read(a[i], 1'b0);
        end
        req = 1'b1; we = 1'b0; wide = 1'b0;
        for (int i = 0; i < 4; i++) begin
            addr = a[i];
            @(negedge clk);
            if (i > 0) begin
                checks++;
                if (dvalid !== 1'b1 || dout !== expv[i-1] || ready !== 1'b1)
                    $display("[TB] FAIL b2b_read%0d: dvalid=%b dout=%h ready=%b, required 1/%h/1",
                             i - 1, dvalid, dout, ready, expv[i-1]);
                else passes++;
            end
        end
        req = 1'b0;
        @(negedge clk);
        checks++;
        if (dvalid !== 1'b1 || dout !== expv[3])
            $display("[TB] FAIL b2b_read3: dvalid=%b dout=%h, required 1/%h", dvalid, dout, expv[3]);
        else passes++;
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [15:0] rd, d, expd;
        int dvc, dvi, oc, rl, nz;
        int a;
        bit w, wd;
        int bad;
        for (int n = 0; n < 150; n++) begin
            a  = (n % 25 == 0) ? 12'hFFF : int'($urandom_range(12'h908, 12'h0F8));
            w  = 1'($urandom_range(1, 0));
            wd = 1'($urandom_range(1, 0));
            d  = 16'($urandom);
            expd = model_read(a, wd);
            applyStimulus(w, wd, 12'(a), d, rd, dvc, dvi, oc, rl, nz);
            bad = 0;
            if (oc !== model_oob(a, wd)) bad = 1;
            if (rl !== (wd ? 1 : 0)) bad = 1;
            if (nz !== 0) bad = 1;
            if (w) begin
                if (dvc !== 0) bad = 1;
                model_write(a, wd, d);
            end else begin
                if (dvc !== 1 || dvi !== (wd ? 2 : 1) || rd !== expd) bad = 1;
            end
            checks++;
            if (bad != 0)
                $display("[TB] FAIL random%0d: a=%h we=%0d wide=%0d dout=%h dvc=%0d at=%0d oob=%0d rl=%0d nz=%0d, required dout=%h oob=%0d",
                         n, a, w, wd, rd, dvc, dvi, oc, rl, nz, expd, model_oob(a, wd));
            else passes++;
        end
    endtask

    task automatic test_reset_mid_word();
        logic [15:0] rd;
        int dvc, dvi, oc, rl, nz;
        int cnt;
        int t;
        t = 0;
        while (ready !== 1'b1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        req = 1'b1; we = 1'b1; wide = 1'b1; addr = 12'h300; di = 16'hA1B2;
        @(negedge clk);
        req = 1'b0; we = 1'b0; wide = 1'b0;
        rst_n = 1'b0;
        model_write(12'h300, 1'b0, 16'hA1B2);
        #2;
        checks++;
        if (dvalid !== 1'b0 || dout !== 16'h0000)
            $display("[TB] FAIL midword_reset_out: dvalid=%b dout=%h, required 0/0000", dvalid, dout);
        else passes++;
        @(negedge clk);
        rst_n = 1'b1;
        wait_ready_after_release(cnt);
        checks++;
        if (cnt !== EXP_CLEAR_CYCLES)
            $display("[TB] FAIL midword_restart_len: %0d cycles, required %0d", cnt, EXP_CLEAR_CYCLES);
        else passes++;
`ifdef DMEM_CLEAR_EN
        model_zero();
`endif
        applyStimulus(1'b0, 1'b1, 12'h300, 16'h0000, rd, dvc, dvi, oc, rl, nz);
        checks++;
        if (rd !== model_read(12'h300, 1'b1) || dvc !== 1)
            $display("[TB] FAIL midword_readback: dout=%h dvc=%0d, required %h/1", rd, dvc, model_read(12'h300, 1'b1));
        else passes++;
    endtask

    initial begin
        model_zero();
        test_reset();
        test_byte();
        test_word();
        test_word_edge();
        test_oob();
        test_back_to_back();
        test_random();
        test_reset_mid_word();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
